decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised RV32I instruction-decode pipeline stage with valid/ready handshakes on both sides. It sits between fetch and the register-file/ALU stage. It decodes each accepted instruction into register indices, use-enables, a sign-correct 32-bit immediate, an instruction class, an illegal flag, and a PC-relative branch/jump target. A 2-entry skid buffer gives full throughput while keeping `in_ready` a registered signal. Unused fields drive 0, never Z.

## Interface
- `PC_W`, default 16: PC and target width.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: synchronous pipeline kill.
- `in_valid` in 1: fetch bundle valid.
- `in_ready` out 1: stage can accept.
- `in_instr` in 32: instruction word.
- `in_pc` in `PC_W`: instruction address.
- `out_valid` in/out: `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: downstream accepts.
- `out_pc` out `PC_W`: pass-through PC.
- `out_opcode` out 7, `out_funct3` out 3, `out_funct7` out 7: instruction fields.
- `out_rs1`, `out_rs2`, `out_rd` out 5 each: register indices.
- `out_rs1_en`, `out_rs2_en`, `out_rd_en` out 1 each: register use flags.
- `out_imm` out 32: final immediate.
- `out_class` out 4: `decode_pkg::iclass_e`.
- `out_tgt` out `PC_W`: pc + imm, valid for B and JAL.
- `out_tgt_en` out 1: `out_tgt` meaningful.
- `out_illegal` out 1: unsupported or reserved encoding.

## Operation
**Classes.** The class is decided by opcode:
- R 0110011, OP_IMM 0010011, LOAD 0000011, STORE 0100011
- BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111
- Anything else is ILLEGAL.

**Immediates.**
- I and JALR: sign-extend `instr[31:20]`.
- OP_IMM with funct3 001/101: zero-extend `instr[24:20]`.
- S: sign-extend `{instr[31:25], instr[11:7]}`.
- B: sign-extend `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
- U: `{instr[31:12], 12'h0}`.
- J: sign-extend `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
- R and ILLEGAL: 0.

**Register enables.**
- `rs1_en`: all classes except LUI, AUIPC, JAL.
- `rs2_en`: R, STORE, BRANCH.
- `rd_en`: all classes except STORE and BRANCH, and forced 0 when `rd`==0.
- Index and funct fields are 0 whenever their enable or class does not use them.

**Illegal when any of:**
- `instr[1:0]`≠11.
- Unknown opcode.
- BRANCH funct3 ∈ {010, 011}.
- LOAD funct3 ∈ {011, 110, 111}.
- STORE funct3 ≥ 011.
- JALR funct3≠000.
- R funct7 ∉ {0000000, 0100000}, or funct7=0100000 with funct3 ∉ {000, 101}.
- OP_IMM shift with `instr[31:25]` ∉ {0000000, 0100000}, or 0100000 with funct3=001.

When illegal, all enables are 0 and `out_imm` is 0.

**Target.**
- `out_tgt = in_pc + out_imm[PC_W-1:0]`, modulo 2^PC_W.
- `out_tgt_en` = 1 for BRANCH and JAL only.
- JALR's target is resolved downstream.

**Skid buffer.** Two entries, main (drives outputs) and skid.
- Accept when `in_valid && in_ready`.
- The decoded bundle goes to main if main is empty or is handshaking this cycle (and skid is empty); otherwise it goes to skid.
- When main is consumed and skid is full, skid moves to main.
- Order is strictly FIFO.
- `in_ready = !skid_full`, taken from a register.

**Flush** (takes priority over everything else):
- Next cycle both entries are empty, `out_valid`=0, `in_ready`=1.
- An input handshaked in the flush cycle is discarded.
- A simultaneous output handshake still counts as consumed.

## Timing
- Latency: accept at edge N, so `out_valid`=1 after edge N. Throughput is 1 per cycle when `out_ready`=1.
- Output stability: while `out_valid && !out_ready`, all `out_*` are held stable.
- After 2 accepts with `out_ready`=0, `in_ready` deasserts the following cycle.
- Reset (`rst`=1, asynchronous): `out_valid`=0, both entries empty, every `out_*` data field=0, `in_ready`=1 immediately.
- Reset mid-transfer drops all buffered bundles. No output handshake occurs in any cycle where `rst` is high.

## Structure
- **`decode_pkg`** holds:
  - opcode localparams;
  - `iclass_e` (R, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, ILLEGAL);
  - `dec_bundle_t` packed struct (all `out_*` fields except the handshake; `PC_W`-dependent fields are passed as a type parameter or kept outside the struct).
- **`rv32_decode_comb`** (sub-module): purely combinational `instr` + `pc` → `dec_bundle_t`, instantiated once on the input side.
- **`decode_stage`**: skid registers and handshake logic.

## Test plan
- **ADDI:** `0xFFF00093` at pc 0x0100 → class OP_IMM, rd=1, `rd_en`=1, rs1=0, `rs1_en`=1, imm=0xFFFFFFFF, `out_illegal`=0, `out_valid` one cycle after accept.
- **BEQ:** `0xFE000CE3` (beq x0,x0,-8) at pc 0x0010 → class BRANCH, imm=0xFFFFFFF8, `out_tgt`=0x0008, `tgt_en`=1, `rd_en`=0, `rs2_en`=1.
- **JAL wrap:** `0x008000EF` (jal x1,+8) at pc 0xFFFC, PC_W=16 → imm=8, `out_tgt`=0x0004, rd=1.
- **Illegal:** `0x00000000` → `out_illegal`=1, all enables 0, imm=0. `0x0000A003` (LOAD funct3=010, legal) → `out_illegal`=0.
- **Backpressure:** send A, B, C back-to-back with `out_ready`=0.
  - `in_ready` falls after A and B are accepted; C is stalled.
  - Raising `out_ready` yields A, B, C in order with no bubble or duplicate.
- **Flush and reset:** with both entries full, pulse `flush` → next cycle `out_valid`=0, `in_ready`=1. Assert `rst` asynchronously mid-stream → outputs zero before the next edge.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared RV32I decode types: opcode constants, instruction classes and the
// PC-width-independent decoded bundle.
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    CLS_R       = 4'd0,
    CLS_OP_IMM  = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LUI     = 4'd5,
    CLS_AUIPC   = 4'd6,
    CLS_JAL     = 4'd7,
    CLS_JALR    = 4'd8,
    CLS_ILLEGAL = 4'd9
  } iclass_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_en;
    logic        rs2_en;
    logic        rd_en;
    logic [31:0] imm;
    iclass_e     iclass;
    logic        tgt_en;
    logic        illegal;
  } dec_bundle_t;

  function automatic iclass_e opcode_class(input logic [6:0] opc);
    iclass_e c;
    case (opc)
      OPC_OP:     c = CLS_R;
      OPC_OP_IMM: c = CLS_OP_IMM;
      OPC_LOAD:   c = CLS_LOAD;
      OPC_STORE:  c = CLS_STORE;
      OPC_BRANCH: c = CLS_BRANCH;
      OPC_LUI:    c = CLS_LUI;
      OPC_AUIPC:  c = CLS_AUIPC;
      OPC_JAL:    c = CLS_JAL;
      OPC_JALR:   c = CLS_JALR;
      default:    c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rv32_decode_comb.sv
// Purely combinational RV32I decoder: instruction word + pc -> decoded bundle
// and pc-relative target.
module rv32_decode_comb
  import decode_pkg::*;
#(
  parameter int unsigned PC_W = 16
) (
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc,
  output dec_bundle_t     dec,
  output logic [PC_W-1:0] tgt
);

  logic [2:0]  f3;
  logic [6:0]  f7;
  iclass_e     cls;
  logic        shift;
  logic        illegal;
  logic        rs1_en;
  logic        rs2_en;
  logic        rd_en;
  logic [31:0] imm_raw;

  always_comb begin
    f3      = instr[14:12];
    f7      = instr[31:25];
    cls     = opcode_class(instr[6:0]);
    shift   = (cls == CLS_OP_IMM) && ((f3 == 3'b001) || (f3 == 3'b101));
    illegal = (instr[1:0] != 2'b11) || (cls == CLS_ILLEGAL);

    case (cls)
      CLS_R: begin
        if (!((f7 == 7'b0000000) || (f7 == 7'b0100000))) illegal = 1'b1;
        if ((f7 == 7'b0100000) && !((f3 == 3'b000) || (f3 == 3'b101))) illegal = 1'b1;
      end
      CLS_OP_IMM: begin
        if (shift && !((f7 == 7'b0000000) || (f7 == 7'b0100000))) illegal = 1'b1;
        if (shift && (f7 == 7'b0100000) && (f3 == 3'b001)) illegal = 1'b1;
      end
      CLS_LOAD:   if ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)) illegal = 1'b1;
      CLS_STORE:  if (f3 >= 3'b011) illegal = 1'b1;
      CLS_BRANCH: if ((f3 == 3'b010) || (f3 == 3'b011)) illegal = 1'b1;
      CLS_JALR:   if (f3 != 3'b000) illegal = 1'b1;
      default: ;
    endcase

    case (cls)
      CLS_LOAD, CLS_JALR: imm_raw = {{20{instr[31]}}, instr[31:20]};
      CLS_OP_IMM:         imm_raw = shift ? {27'd0, instr[24:20]}
                                          : {{20{instr[31]}}, instr[31:20]};
      CLS_STORE:          imm_raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      CLS_BRANCH:         imm_raw = {{19{instr[31]}}, instr[31], instr[7],
                                     instr[30:25], instr[11:8], 1'b0};
      CLS_LUI, CLS_AUIPC: imm_raw = {instr[31:12], 12'h000};
      CLS_JAL:            imm_raw = {{11{instr[31]}}, instr[31], instr[19:12],
                                     instr[20], instr[30:21], 1'b0};
      default:            imm_raw = '0;
    endcase

    rs1_en = !illegal && !(cls inside {CLS_LUI, CLS_AUIPC, CLS_JAL});
    rs2_en = !illegal && (cls inside {CLS_R, CLS_STORE, CLS_BRANCH});
    rd_en  = !illegal && !(cls inside {CLS_STORE, CLS_BRANCH}) && (instr[11:7] != 5'd0);

    dec         = '0;
    dec.opcode  = instr[6:0];
    dec.funct3  = (cls inside {CLS_R, CLS_OP_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JALR})
                  ? f3 : 3'd0;
    dec.funct7  = ((cls == CLS_R) || shift) ? f7 : 7'd0;
    dec.rs1     = rs1_en ? instr[19:15] : 5'd0;
    dec.rs2     = rs2_en ? instr[24:20] : 5'd0;
    dec.rd      = rd_en  ? instr[11:7]  : 5'd0;
    dec.rs1_en  = rs1_en;
    dec.rs2_en  = rs2_en;
    dec.rd_en   = rd_en;
    dec.imm     = illegal ? '0 : imm_raw;
    dec.iclass  = cls;
    dec.tgt_en  = !illegal && ((cls == CLS_BRANCH) || (cls == CLS_JAL));
    dec.illegal = illegal;
  end

  assign tgt = pc + dec.imm[PC_W-1:0];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: decodes on the input side, then holds results
// in a 2-entry (main + skid) buffer with a registered in_ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned PC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rs1_en,
  output logic            out_rs2_en,
  output logic            out_rd_en,
  output logic [31:0]     out_imm,
  output logic [3:0]      out_class,
  output logic [PC_W-1:0] out_tgt,
  output logic            out_tgt_en,
  output logic            out_illegal
);

  dec_bundle_t     in_dec;
  logic [PC_W-1:0] in_tgt;

  dec_bundle_t     main_q, main_d, skid_q, skid_d;
  logic [PC_W-1:0] main_pc_q, main_pc_d, main_tgt_q, main_tgt_d;
  logic [PC_W-1:0] skid_pc_q, skid_pc_d, skid_tgt_q, skid_tgt_d;
  logic            main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic            ready_q, ready_d;
  logic            in_fire, out_fire;

  rv32_decode_comb #(.PC_W(PC_W)) u_dec (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (in_dec),
    .tgt   (in_tgt)
  );

  always_comb begin
    main_d     = main_q;
    main_pc_d  = main_pc_q;
    main_tgt_d = main_tgt_q;
    skid_d     = skid_q;
    skid_pc_d  = skid_pc_q;
    skid_tgt_d = skid_tgt_q;
    main_v_d   = main_v_q;
    skid_v_d   = skid_v_q;
    in_fire    = in_valid && ready_q;
    out_fire   = main_v_q && out_ready;

    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || out_fire) begin
      // ready_q is low whenever skid is full, so a promotion and an accept never coincide
      if (skid_v_q) begin
        main_d     = skid_q;
        main_pc_d  = skid_pc_q;
        main_tgt_d = skid_tgt_q;
        main_v_d   = 1'b1;
        skid_v_d   = 1'b0;
      end else begin
        main_v_d = in_fire;
        if (in_fire) begin
          main_d     = in_dec;
          main_pc_d  = in_pc;
          main_tgt_d = in_tgt;
        end
      end
    end else if (in_fire) begin
      skid_d     = in_dec;
      skid_pc_d  = in_pc;
      skid_tgt_d = in_tgt;
      skid_v_d   = 1'b1;
    end

    ready_d = !skid_v_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      main_pc_q  <= '0;
      main_tgt_q <= '0;
      skid_q     <= '0;
      skid_pc_q  <= '0;
      skid_tgt_q <= '0;
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      main_q     <= main_d;
      main_pc_q  <= main_pc_d;
      main_tgt_q <= main_tgt_d;
      skid_q     <= skid_d;
      skid_pc_q  <= skid_pc_d;
      skid_tgt_q <= skid_tgt_d;
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      ready_q    <= ready_d;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = main_v_q;
  assign out_pc      = main_pc_q;
  assign out_opcode  = main_q.opcode;
  assign out_funct3  = main_q.funct3;
  assign out_funct7  = main_q.funct7;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_rd      = main_q.rd;
  assign out_rs1_en  = main_q.rs1_en;
  assign out_rs2_en  = main_q.rs2_en;
  assign out_rd_en   = main_q.rd_en;
  assign out_imm     = main_q.imm;
  assign out_class   = main_q.iclass;
  assign out_tgt     = main_tgt_q;
  assign out_tgt_en  = main_q.tgt_en;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: hand-derived expected bundles are queued
// on input handshakes and compared on output handshakes.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [15:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rs1_en, out_rs2_en, out_rd_en;
  logic [31:0] out_imm;
  logic [3:0]  out_class;
  logic [15:0] out_tgt;
  logic        out_tgt_en;
  logic        out_illegal;

  decode_stage #(.PC_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en), .out_rd_en(out_rd_en),
    .out_imm(out_imm), .out_class(out_class), .out_tgt(out_tgt),
    .out_tgt_en(out_tgt_en), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    iclass_e     cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        rd_en;
    logic        rs1_en;
    logic        rs2_en;
    logic [31:0] imm;
    logic [15:0] tgt;
    logic        tgt_en;
    logic        illegal;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  vec_t        vecs[11];
  exp_t        sb[$];
  exp_t        cur_exp;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_pc;
  logic [31:0] prev_imm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic [15:0] pc, input iclass_e cls,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic rd_en,
                              input logic rs1_en, input logic rs2_en, input logic [31:0] imm,
                              input logic [15:0] tgt, input logic tgt_en, input logic illegal);
    vec_t v;
    v.instr = instr;
    v.e = '{pc, cls, rd, rs1, rd_en, rs1_en, rs2_en, imm, tgt, tgt_en, illegal};
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_pc", 32'(out_pc), 32'(prev_pc));
        chk("hold_imm", out_imm, prev_imm);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("pc", 32'(out_pc), 32'(e.pc));
          chk("class", 32'(out_class), 32'(e.cls));
          chk("rd", 32'(out_rd), 32'(e.rd));
          chk("rs1", 32'(out_rs1), 32'(e.rs1));
          chk("rd_en", 32'(out_rd_en), 32'(e.rd_en));
          chk("rs1_en", 32'(out_rs1_en), 32'(e.rs1_en));
          chk("rs2_en", 32'(out_rs2_en), 32'(e.rs2_en));
          chk("imm", out_imm, e.imm);
          chk("tgt_en", 32'(out_tgt_en), 32'(e.tgt_en));
          chk("illegal", 32'(out_illegal), 32'(e.illegal));
          if (e.tgt_en) chk("tgt", 32'(out_tgt), 32'(e.tgt));
        end
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_pc    = out_pc;
      prev_imm   = out_imm;
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  task automatic send(input int unsigned i);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_instr = vecs[i].instr;
    in_pc    = vecs[i].e.pc;
    cur_exp  = vecs[i].e;
    for (int c = 0; c < 40 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready && !rst;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(32'hFFF00093, 16'h0100, CLS_OP_IMM, 5'd1, 5'd0, 1, 1, 0, 32'hFFFFFFFF, 16'h0000, 0, 0);
    vecs[1]  = mk(32'hFE000CE3, 16'h0010, CLS_BRANCH, 5'd0, 5'd0, 0, 1, 1, 32'hFFFFFFF8, 16'h0008, 1, 0);
    vecs[2]  = mk(32'h008000EF, 16'hFFFC, CLS_JAL,    5'd1, 5'd0, 1, 0, 0, 32'h00000008, 16'h0004, 1, 0);
    vecs[3]  = mk(32'h00000000, 16'h0200, CLS_ILLEGAL,5'd0, 5'd0, 0, 0, 0, 32'h00000000, 16'h0000, 0, 1);
    vecs[4]  = mk(32'h0000A003, 16'h0204, CLS_LOAD,   5'd0, 5'd1, 0, 1, 0, 32'h00000000, 16'h0000, 0, 0);
    vecs[5]  = mk(32'h402081B3, 16'h0208, CLS_R,      5'd3, 5'd1, 1, 1, 1, 32'h00000000, 16'h0000, 0, 0);
    vecs[6]  = mk(32'h402091B3, 16'h020C, CLS_R,      5'd0, 5'd0, 0, 0, 0, 32'h00000000, 16'h0000, 0, 1);
    vecs[7]  = mk(32'hFE20AE23, 16'h0210, CLS_STORE,  5'd0, 5'd1, 0, 1, 1, 32'hFFFFFFFC, 16'h0000, 0, 0);
    vecs[8]  = mk(32'h123452B7, 16'h0214, CLS_LUI,    5'd5, 5'd0, 1, 0, 0, 32'h12345000, 16'h0000, 0, 0);
    vecs[9]  = mk(32'h4030D093, 16'h0218, CLS_OP_IMM, 5'd1, 5'd1, 1, 1, 0, 32'h00000003, 16'h0000, 0, 0);
    vecs[10] = mk(32'h000090E7, 16'h021C, CLS_JALR,   5'd0, 5'd0, 0, 0, 0, 32'h00000000, 16'h0000, 0, 1);

    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // latency: output valid right after the accepting edge
    out_ready = 1'b0;
    send(0);
    chk("latency_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;

    for (int unsigned i = 1; i < 11; i++) send(i);
    drain();

    // backpressure: A,B fill both entries, C stalls, then all drain in order
    out_ready = 1'b0;
    send(0);
    send(1);
    chk("ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_instr = vecs[2].instr;
    in_pc    = vecs[2].e.pc;
    cur_exp  = vecs[2].e;
    repeat (3) begin
      @(posedge clk);
      #1 chk("c_stalled", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk) chk("no_bubble_a", 32'(out_valid), 32'd1);
    @(posedge clk) #1;
    @(negedge clk) chk("no_bubble_b", 32'(out_valid), 32'd1);
    @(posedge clk) #1 in_valid = 1'b0;
    @(negedge clk) chk("no_bubble_c", 32'(out_valid), 32'd1);
    drain();

    // flush with both entries full
    out_ready = 1'b0;
    send(3);
    send(4);
    chk("full_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    @(posedge clk) #1 flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(5);
    drain();

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    send(8);
    send(9);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_imm", out_imm, 32'd0);
    chk("arst_pc", 32'(out_pc), 32'd0);
    chk("arst_rd", 32'(out_rd), 32'd0);
    @(posedge clk) #1 rst = 1'b0;
    out_ready = 1'b1;
    send(7);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
